// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 instruction-fetch engine.
package slc3_pkg;

    localparam int unsigned MAX_MEM_LATENCY = 7;
    localparam int unsigned CNT_W           = $clog2(MAX_MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_FETCH3 = 3'd3,
        ST_PAUSE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector; the delayed copy is sampled every cycle.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise_c
);

    logic r_d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= i_d;
        end
    end

    assign o_rise_c = i_d & ~r_d_q;

endmodule

// File: rtl/load_reg.sv
// Loadable register with synchronous reset to a fixed value.
module load_reg #(
    parameter int unsigned     WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/slc3_fetch_ctrl.sv
// SLC-3 fetch engine: owns PC/MAR/MDR/IR and sequences reads against a
// fixed-latency memory port, with single-step pausing and queued redirects.
module slc3_fetch_ctrl
    import slc3_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           MEM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter bit                    PAUSE_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_i,
    input  logic                  continue_i,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_mem_ena,
    output logic                  mem_wr_ena,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic                  ir_valid,
    output logic [2:0]            state_o,
    output logic [DATA_WIDTH-1:0] hex_display_debug,
    output logic [DATA_WIDTH-1:0] led_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_redir_pend;
    logic [DATA_WIDTH-1:0] r_redir_pc;
    logic                  r_ir_valid;
    logic                  r_mem_ena;

    logic                  w_run_rise;
    logic                  w_cont_rise;
    logic                  w_pc_ld;
    logic                  w_mar_ld;
    logic                  w_mdr_ld;
    logic                  w_ir_ld;
    logic [DATA_WIDTH-1:0] w_pc_d;
    logic [DATA_WIDTH-1:0] w_mar_d;
    logic [DATA_WIDTH-1:0] w_pc_q;
    logic [DATA_WIDTH-1:0] w_mar_q;
    logic [DATA_WIDTH-1:0] w_mdr_q;
    logic [DATA_WIDTH-1:0] w_ir_q;

    edge_detect u_run_edge (
        .clk      (clk),
        .reset    (reset),
        .i_d      (run_i),
        .o_rise_c (w_run_rise)
    );

    edge_detect u_cont_edge (
        .clk      (clk),
        .reset    (reset),
        .i_d      (continue_i),
        .o_rise_c (w_cont_rise)
    );

    load_reg #(.WIDTH(DATA_WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .i_ld(w_pc_ld), .i_d(w_pc_d), .o_q(w_pc_q)
    );

    load_reg #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_mar (
        .clk(clk), .reset(reset), .i_ld(w_mar_ld), .i_d(w_mar_d), .o_q(w_mar_q)
    );

    load_reg #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_mdr (
        .clk(clk), .reset(reset), .i_ld(w_mdr_ld), .i_d(mem_rdata), .o_q(w_mdr_q)
    );

    load_reg #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_ir (
        .clk(clk), .reset(reset), .i_ld(w_ir_ld), .i_d(w_mdr_q), .o_q(w_ir_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HALTED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_ld      = 1'b0;
        w_mar_ld     = 1'b0;
        w_mdr_ld     = 1'b0;
        w_ir_ld      = 1'b0;
        w_mar_d      = w_pc_q;
        w_pc_d       = w_pc_q + DATA_WIDTH'(1);
        case (r_state)
            ST_HALTED: begin
                if (w_run_rise) begin
                    w_next_state = ST_FETCH1;
                end
            end
            ST_FETCH1: begin
                w_mar_ld = 1'b1;
                w_pc_ld  = 1'b1;
                if (r_redir_pend) begin
                    w_mar_d = r_redir_pc;
                    w_pc_d  = r_redir_pc + DATA_WIDTH'(1);
                end
                w_next_state = ST_FETCH2;
            end
            ST_FETCH2: begin
                if (r_cnt == LAST_CNT) begin
                    w_mdr_ld     = 1'b1;
                    w_next_state = ST_FETCH3;
                end
            end
            ST_FETCH3: begin
                w_ir_ld      = 1'b1;
                w_next_state = PAUSE_EN ? ST_PAUSE : ST_FETCH1;
            end
            ST_PAUSE: begin
                if (w_cont_rise) begin
                    w_next_state = ST_FETCH1;
                end
            end
            default: w_next_state = ST_HALTED;
        endcase
    end

    // A redirect arriving in the FETCH1 cycle is kept for the following fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
            r_ir_valid   <= 1'b0;
            r_mem_ena    <= 1'b0;
        end else begin
            if (r_state == ST_FETCH1) begin
                r_cnt <= '0;
            end else if (r_state == ST_FETCH2) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (redirect_valid) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= redirect_pc;
            end else if (r_state == ST_FETCH1) begin
                r_redir_pend <= 1'b0;
            end
            r_ir_valid <= (r_state == ST_FETCH3);
            r_mem_ena  <= (w_next_state == ST_FETCH2);
        end
    end

    assign mem_addr          = w_mar_q;
    assign mem_wdata         = w_mdr_q;
    assign mem_mem_ena       = r_mem_ena;
    assign mem_wr_ena        = 1'b0;
    assign pc_o              = w_pc_q;
    assign ir_o              = w_ir_q;
    assign ir_valid          = r_ir_valid;
    assign state_o           = r_state;
    assign hex_display_debug = w_ir_q;
    assign led_o             = w_ir_q;

endmodule

// File: tb/tb_slc3_fetch_ctrl.sv
// Bench for slc3_fetch_ctrl: three configurations, latency-aware memory model,
// directed scenarios plus a randomized single-step/redirect run.
module tb_slc3_fetch_ctrl;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;
    localparam int unsigned LAT2 = 1;

    logic        clk;
    logic        rst   [3];
    logic        run   [3];
    logic        cont  [3];
    logic        rv    [3];
    logic [15:0] rpc   [3];
    logic [15:0] rdata [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic        ena   [3];
    logic        wr    [3];
    logic [15:0] pc    [3];
    logic [15:0] ir    [3];
    logic        irv   [3];
    logic [2:0]  st    [3];
    logic [15:0] hex   [3];
    logic [15:0] led   [3];

    int          mcnt  [3];
    logic [15:0] garb  [3];
    int unsigned seed;
    int          ncmp;
    int          nfail;

    slc3_fetch_ctrl #(.DATA_WIDTH(16), .MEM_LATENCY(LAT0), .RESET_PC(16'h0000), .PAUSE_EN(1'b1)) u_a (
        .clk(clk), .reset(rst[0]), .run_i(run[0]), .continue_i(cont[0]),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .mem_rdata(rdata[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_mem_ena(ena[0]), .mem_wr_ena(wr[0]),
        .pc_o(pc[0]), .ir_o(ir[0]), .ir_valid(irv[0]), .state_o(st[0]),
        .hex_display_debug(hex[0]), .led_o(led[0])
    );

    slc3_fetch_ctrl #(.DATA_WIDTH(16), .MEM_LATENCY(LAT1), .RESET_PC(16'hFFFF), .PAUSE_EN(1'b1)) u_b (
        .clk(clk), .reset(rst[1]), .run_i(run[1]), .continue_i(cont[1]),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .mem_rdata(rdata[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_mem_ena(ena[1]), .mem_wr_ena(wr[1]),
        .pc_o(pc[1]), .ir_o(ir[1]), .ir_valid(irv[1]), .state_o(st[1]),
        .hex_display_debug(hex[1]), .led_o(led[1])
    );

    slc3_fetch_ctrl #(.DATA_WIDTH(16), .MEM_LATENCY(LAT2), .RESET_PC(16'h0000), .PAUSE_EN(1'b0)) u_c (
        .clk(clk), .reset(rst[2]), .run_i(run[2]), .continue_i(cont[2]),
        .redirect_valid(rv[2]), .redirect_pc(rpc[2]), .mem_rdata(rdata[2]),
        .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_mem_ena(ena[2]), .mem_wr_ena(wr[2]),
        .pc_o(pc[2]), .ir_o(ir[2]), .ir_valid(irv[2]), .state_o(st[2]),
        .hex_display_debug(hex[2]), .led_o(led[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned lat_of(input int i);
        return (i == 1) ? LAT1 : ((i == 2) ? LAT2 : LAT0);
    endfunction

    function automatic logic [15:0] memw(input int i, input logic [15:0] a);
        if (a == 16'h0000) return (i == 1) ? 16'hABCD : 16'h1234;
        return 16'((32'(a) * 32'h0000_9E37) ^ 32'h0000_5A5A ^ seed);
    endfunction

    // Memory returns real data only in the last enabled cycle; junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ena[i] === 1'b1) mcnt[i] <= mcnt[i] + 1;
            else                 mcnt[i] <= 0;
            garb[i] <= 16'($urandom);
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if ((ena[i] === 1'b1) && (mcnt[i] == int'(lat_of(i)) - 1)) rdata[i] = memw(i, addr[i]);
            else                                                       rdata[i] = garb[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_irv(input int i, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (irv[i] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("irv_wait%0d", i), 32'(seen), 32'd1);
    endtask

    initial begin
        int          n_ena;
        int          n_irv;
        logic        c;
        logic        v;
        logic [15:0] rp;
        logic        rise;
        logic        m_prevc;
        logic        m_active;
        logic        m_pend;
        int          m_age;
        logic [15:0] m_pc;
        logic [15:0] m_addr;
        logic [15:0] m_rpc;
        logic        exp_ena;
        logic        exp_irv;

        ncmp  = 0;
        nfail = 0;
        seed  = $urandom;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; run[i] = 1'b0; cont[i] = 1'b0; rv[i] = 1'b0; rpc[i] = 16'h0;
            mcnt[i] = 0; garb[i] = 16'h0;
        end
        step(); step();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        chk("rst_state", 32'(st[0]), 32'd0);
        chk("rst_pc", 32'(pc[0]), 32'h0);
        chk("rst_pc_b", 32'(pc[1]), 32'hFFFF);
        chk("rst_ir", 32'(ir[0]), 32'h0);
        chk("rst_ena", 32'(ena[0]), 32'd0);
        chk("rst_irv", 32'(irv[0]), 32'd0);
        chk("rst_addr", 32'(addr[0]), 32'h0);

        // Instance A: first fetch, cycle by cycle
        run[0] = 1'b1;
        step(); chk("a_f1_state", 32'(st[0]), 32'd1);
        step(); chk("a_f2_state", 32'(st[0]), 32'd2);
                chk("a_f2_ena", 32'(ena[0]), 32'd1);
                chk("a_f2_addr", 32'(addr[0]), 32'h0);
        step(); chk("a_f3_ena", 32'(ena[0]), 32'd0);
                chk("a_f3_state", 32'(st[0]), 32'd3);
        step(); chk("a_ir", 32'(ir[0]), 32'h1234);
                chk("a_irv", 32'(irv[0]), 32'd1);
                chk("a_pc", 32'(pc[0]), 32'd1);
                chk("a_pause", 32'(st[0]), 32'd4);
                chk("a_led", 32'(led[0]), 32'h1234);
                chk("a_hex", 32'(hex[0]), 32'h1234);
                chk("a_wdata", 32'(wdata[0]), 32'h1234);
                chk("a_wr", 32'(wr[0]), 32'd0);
        step(); chk("a_irv_drop", 32'(irv[0]), 32'd0);

        // Held continue produces exactly one fetch
        cont[0] = 1'b1;
        n_ena = 0; n_irv = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ena[0] === 1'b1) n_ena++;
            if (irv[0] === 1'b1) n_irv++;
        end
        cont[0] = 1'b0;
        chk("a_hold_ena", 32'(n_ena), 32'd1);
        chk("a_hold_irv", 32'(n_irv), 32'd1);
        chk("a_ir1", 32'(ir[0]), 32'(memw(0, 16'd1)));
        chk("a_pc2", 32'(pc[0]), 32'd2);
        step();
        cont[0] = 1'b1;
        wait_irv(0, 20);
        cont[0] = 1'b0;
        chk("a_ir2", 32'(ir[0]), 32'(memw(0, 16'd2)));
        chk("a_pc3", 32'(pc[0]), 32'd3);

        // run rising in PAUSE must not start a fetch
        run[0] = 1'b0; step();
        run[0] = 1'b1; step(); step(); step();
        chk("a_run_ign", 32'(st[0]), 32'd4);
        chk("a_run_ign_pc", 32'(pc[0]), 32'd3);

        // Two queued redirects: the later one wins
        rv[0] = 1'b1; rpc[0] = 16'h3000; step();
        rpc[0] = 16'h4000; step();
        rv[0] = 1'b0; step();
        cont[0] = 1'b1; step(); chk("a_rd_f1", 32'(st[0]), 32'd1);
        step(); chk("a_rd_addr", 32'(addr[0]), 32'h4000);
                chk("a_rd_ena", 32'(ena[0]), 32'd1);
        wait_irv(0, 20);
        chk("a_rd_pc", 32'(pc[0]), 32'h4001);
        chk("a_rd_ir", 32'(ir[0]), 32'(memw(0, 16'h4000)));
        cont[0] = 1'b0; step();

        // Redirect coincident with FETCH1 is deferred one fetch
        cont[0] = 1'b1; step(); chk("a_co_f1", 32'(st[0]), 32'd1);
        rv[0] = 1'b1; rpc[0] = 16'h5000;
        step(); rv[0] = 1'b0;
        chk("a_co_addr", 32'(addr[0]), 32'h4001);
        wait_irv(0, 20);
        chk("a_co_pc", 32'(pc[0]), 32'h4002);
        cont[0] = 1'b0; step();
        cont[0] = 1'b1; step(); step();
        chk("a_co_addr2", 32'(addr[0]), 32'h5000);
        wait_irv(0, 20);
        chk("a_co_pc2", 32'(pc[0]), 32'h5001);
        chk("a_co_ir2", 32'(ir[0]), 32'(memw(0, 16'h5000)));
        cont[0] = 1'b0;

        // Instance C: free-run at a three-cycle period
        run[2] = 1'b1;
        wait_irv(2, 20);
        chk("c_ir0", 32'(ir[2]), 32'h1234);
        chk("c_pc0", 32'(pc[2]), 32'd1);
        for (int f = 1; f <= 2; f++) begin
            step(); chk("c_gap1", 32'(irv[2]), 32'd0);
            step(); chk("c_gap2", 32'(irv[2]), 32'd0);
            step(); chk("c_irv", 32'(irv[2]), 32'd1);
            chk("c_ir", 32'(ir[2]), 32'(memw(2, 16'(f))));
            chk("c_pc", 32'(pc[2]), 32'(f + 1));
        end

        // Instance B: PC wrap then latency-3 fetch with junk before data
        run[1] = 1'b1;
        wait_irv(1, 20);
        chk("b_ir_ffff", 32'(ir[1]), 32'(memw(1, 16'hFFFF)));
        chk("b_wrap_pc", 32'(pc[1]), 32'h0);
        step();
        cont[1] = 1'b1; step();
        n_ena = 0; n_irv = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ena[1] === 1'b1) n_ena++;
            if (irv[1] === 1'b1) n_irv++;
        end
        cont[1] = 1'b0;
        chk("b_ena_cnt", 32'(n_ena), 32'd3);
        chk("b_irv_cnt", 32'(n_irv), 32'd1);
        chk("b_ir_abcd", 32'(ir[1]), 32'hABCD);
        chk("b_pc1", 32'(pc[1]), 32'd1);
        step();

        // Randomized continue/redirect traffic against a timeline model
        m_prevc = 1'b0; m_active = 1'b0; m_pend = 1'b0; m_age = 0;
        m_pc = 16'd1; m_addr = 16'd0; m_rpc = 16'd0;
        for (int n = 0; n < 400; n++) begin
            c  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 5) == 0);
            rp = 16'($urandom);
            cont[1] = c; rv[1] = v; rpc[1] = rp;
            step();
            rise    = c && !m_prevc;
            m_prevc = c;
            if (m_active) begin
                m_age++;
                if (m_age == 1) begin
                    m_addr = m_pend ? m_rpc : m_pc;
                    m_pc   = m_addr + 16'd1;
                    m_pend = 1'b0;
                end
            end else if (rise) begin
                m_active = 1'b1;
                m_age    = 0;
            end
            if (v) begin
                m_pend = 1'b1;
                m_rpc  = rp;
            end
            exp_ena = m_active && (m_age >= 1) && (m_age <= int'(LAT1));
            exp_irv = m_active && (m_age == int'(LAT1) + 2);
            chk("rnd_ena", 32'(ena[1]), 32'(exp_ena));
            chk("rnd_pc", 32'(pc[1]), 32'(m_pc));
            chk("rnd_irv", 32'(irv[1]), 32'(exp_irv));
            if (exp_ena) chk("rnd_addr", 32'(addr[1]), 32'(m_addr));
            if (exp_irv) begin
                chk("rnd_ir", 32'(ir[1]), 32'(memw(1, m_addr)));
                m_active = 1'b0;
            end
        end

        // Reset during FETCH2 aborts the fetch
        cont[1] = 1'b0; rv[1] = 1'b0;
        for (int k = 0; k < 10; k++) step();
        cont[1] = 1'b1; step();
        step(); chk("b_mid_f2", 32'(st[1]), 32'd2);
        rst[1] = 1'b1;
        step(); rst[1] = 1'b0;
        chk("b_rst_state", 32'(st[1]), 32'd0);
        chk("b_rst_ena", 32'(ena[1]), 32'd0);
        chk("b_rst_ir", 32'(ir[1]), 32'h0);
        chk("b_rst_pc", 32'(pc[1]), 32'hFFFF);
        chk("b_rst_irv", 32'(irv[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
